// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - instruction memory clear/load/run controller
// Clears the memory to NOP_WORD, accepts a streamed program, then serves zero-latency fetches.
module imem_load_ctrl #(
  parameter int          DEPTH    = 128,
  parameter int          AW       = 7,
  parameter logic [31:0] NOP_WORD = 32'd0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start_load,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic [AW-1:0] PC,
  input  logic          stall,
  output logic [31:0]   Instruction,
  output logic          cpu_hold,
  output logic [AW:0]   loaded_count,
  output logic          load_err
);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_clr_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;
  logic          w_xfer;
  logic          w_clr_done;
  logic          w_wr_full;
  logic          w_pc_ok;

  assign w_clr_done = (r_clr_ptr == LAST_ADDR);
  assign w_wr_full  = (r_wr_ptr == LAST_ADDR);
  assign w_pc_ok    = ({1'b0, PC} < DEPTH_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_CLEAR;
    else          r_state <= w_next;
  end

  // Handshake and hold are decoded only from the registered state.
  always_comb begin
    w_next   = r_state;
    ld_ready = 1'b0;
    cpu_hold = 1'b1;
    w_we     = 1'b0;
    w_waddr  = r_clr_ptr;
    w_wdata  = NOP_WORD;
    w_xfer   = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_we = 1'b1;
        if (w_clr_done) w_next = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        w_xfer   = ld_valid;
        if (ld_valid) begin
          w_we    = 1'b1;
          w_waddr = r_wr_ptr;
          w_wdata = ld_data;
          if (ld_last || w_wr_full) w_next = S_RUN;
        end
      end
      S_RUN: begin
        cpu_hold = 1'b0;
        if (start_load) w_next = S_CLEAR;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_ptr <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: r_clr_ptr <= w_clr_done ? '0 : r_clr_ptr + 1'b1;
        S_LOAD: begin
          if (w_xfer) begin
            r_count <= r_count + 1'b1;
            // The pointer saturates at the top so address 0 is never overwritten.
            if (!w_wr_full) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_wr_full && !ld_last) r_err <= 1'b1;
          end
        end
        S_RUN: begin
          if (start_load) begin
            r_clr_ptr <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign Instruction  = (r_state == S_RUN && !stall && w_pc_ok) ? r_mem[PC] : NOP_WORD;
  assign loaded_count = r_count;
  assign load_err     = r_err;

endmodule
